// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int WIDTH    = 16;
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 12;
   localparam int COND_MSB = 11;
   localparam int COND_LSB = 9;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_NOT  = 4'h5,
      OP_SLL  = 4'h6,
      OP_SRL  = 4'h7,
      OP_LW   = 4'h8,
      OP_SW   = 4'h9,
      OP_LI   = 4'hA,
      OP_BR   = 4'hB,
      OP_JAL  = 4'hC,
      OP_JR   = 4'hD,
      OP_HALT = 4'hE,
      OP_EXEC = 4'hF
   } opcode_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic             imem_req;
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rdata;
   logic             imem_ready;

   modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_unit_skid_buf.sv
// One-entry buffer holding a word fetched while decode was stalled.
module fetch_skid_buf
   import fetch_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d_instr,
   input  logic [WIDTH-1:0] d_pc_plus1,
   output logic             valid,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] pc_plus1
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         instr    <= '0;
         pc_plus1 <= '0;
      end else if (clear) begin
         valid    <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= d_instr;
         pc_plus1 <= d_pc_plus1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request FSM and the IF/ID pipeline register.
//   state | meaning
//   BOOT  | first cycle out of reset, no request
//   REQ   | requesting imem at pc
//   HOLD  | decode stalled with one fetched word parked in the skid buffer
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [WIDTH-1:0]  redirect_pc,
   fetch_unit_if.master      mem,
   output logic              ifid_valid,
   output logic [WIDTH-1:0]  ifid_instr,
   output logic [WIDTH-1:0]  ifid_pc_plus1,
   output logic [3:0]        ifid_opcode,
   output logic [2:0]        ifid_cond
);

   fetch_state_e     state;
   logic             req_q;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_inc;
   logic             skid_load;
   logic             skid_clear;
   logic             skid_valid;
   logic [WIDTH-1:0] skid_instr;
   logic [WIDTH-1:0] skid_pc_plus1;

   assign pc_inc        = pc + 16'd1;
   assign mem.imem_addr = pc;
   assign mem.imem_req  = req_q;
   assign ifid_opcode   = ifid_instr[OPC_MSB:OPC_LSB];
   assign ifid_cond     = ifid_instr[COND_MSB:COND_LSB];

   // A word can only be parked on the edge REQ->HOLD, and is drained or dropped on leaving HOLD.
   assign skid_load  = (state == REQ) && mem.imem_ready && stall && !redirect_valid;
   assign skid_clear = redirect_valid || ((state == HOLD) && !stall);

   fetch_skid_buf u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (skid_load),
      .clear      (skid_clear),
      .d_instr    (mem.imem_rdata),
      .d_pc_plus1 (pc_inc),
      .valid      (skid_valid),
      .instr      (skid_instr),
      .pc_plus1   (skid_pc_plus1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= BOOT;
         req_q         <= 1'b0;
         pc            <= RESET_PC;
         ifid_valid    <= 1'b0;
         ifid_instr    <= NOP_INSTR;
         ifid_pc_plus1 <= '0;
      end else if (redirect_valid) begin
         state      <= REQ;
         req_q      <= 1'b1;
         pc         <= redirect_pc;
         ifid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
      end else begin
         case (state)
            BOOT: begin
               state <= REQ;
               req_q <= 1'b1;
            end
            REQ: begin
               if (mem.imem_ready)
                  pc <= pc_inc;
               if (!stall) begin
                  if (mem.imem_ready) begin
                     ifid_valid    <= 1'b1;
                     ifid_instr    <= mem.imem_rdata;
                     ifid_pc_plus1 <= pc_inc;
                  end else begin
                     ifid_valid <= 1'b0;
                     ifid_instr <= NOP_INSTR;
                  end
               end else if (mem.imem_ready) begin
                  state <= HOLD;
                  req_q <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state         <= REQ;
                  req_q         <= 1'b1;
                  ifid_valid    <= skid_valid;
                  ifid_instr    <= skid_valid ? skid_instr : NOP_INSTR;
                  ifid_pc_plus1 <= skid_pc_plus1;
               end
            end
            default: begin
               state <= BOOT;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
